// File: rtl/usr_defs.sv
// Shared definitions for the usr_sync shift register: operation encodings
// and a helper that classifies the counting operations.
package usr_defs;

   // Operation select; the two reserved codes behave as hold.
   typedef enum logic [2:0] {
      HOLD = 3'b000,
      SHL  = 3'b001,
      SHR  = 3'b010,
      ROL  = 3'b011,
      ROR  = 3'b100,
      LOAD = 3'b101,
      RSV6 = 3'b110,
      RSV7 = 3'b111
   } mode_e;

   // True for the operations that advance the shift counter.
   function automatic logic is_shift(input mode_e m);
      return m inside {SHL, SHR, ROL, ROR};
   endfunction

endpackage

// File: rtl/usr_sync_if.sv
// Control/data bundle of the usr_sync register. The master drives the
// operation inputs; the slave (the register) returns contents and taps.
interface usr_sync_if
   import usr_defs::*;
#(
   parameter int WIDTH = 8
) ();

   logic             set;
   logic             en;
   mode_e            mode;
   logic [WIDTH-1:0] d;
   logic             sin_l;
   logic             sin_r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic             sout_l;
   logic             sout_r;
   logic             done;

   modport master (
      output set, en, mode, d, sin_l, sin_r,
      input  q, qbar, sout_l, sout_r, done
   );

   modport slave (
      input  set, en, mode, d, sin_l, sin_r,
      output q, qbar, sout_l, sout_r, done
   );

endinterface

// File: rtl/usr_shift_cnt.sv
// Shift counter: counts enabled shift/rotate operations modulo WIDTH and
// emits a registered one-cycle done pulse on each wrap.
module usr_shift_cnt #(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic done
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt;

   // Count operations; reset beats clear beats increment, done defaults low.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         done <= 1'b0;
      end else if (inc) begin
         if (cnt == LAST) begin
            cnt  <= '0;
            done <= 1'b1;
         end else begin
            cnt  <= cnt + CW'(1);
            done <= 1'b0;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/usr_sync.sv
// Universal shift register: hold, shift/rotate left/right and parallel load,
// with synchronous reset and preset, complement/serial taps and a done pulse
// after every WIDTH shift/rotate operations.
module usr_sync
   import usr_defs::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
   input  logic       clk,
   input  logic       reset,
   usr_sync_if.slave  bus
);

   logic [WIDTH-1:0] q;
   logic             clr;
   logic             inc;

   // Decode counter control: set or an enabled load clears, an enabled
   // shift/rotate counts. Reset is applied inside the counter itself.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      clr = 1'b0;
      inc = 1'b0;
      if (bus.set) begin
         clr = 1'b1;
      end else if (bus.en) begin
         clr = (bus.mode == LOAD);
         inc = is_shift(bus.mode);
      end
   end

   // Register update with priority reset > set > hold (en low) > mode.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         q <= RESET_VAL;
      end else if (bus.set) begin
         q <= SET_VAL;
      end else if (bus.en) begin
         case (bus.mode)
            SHL:     q <= {q[WIDTH-2:0], bus.sin_l};
            SHR:     q <= {bus.sin_r, q[WIDTH-1:1]};
            ROL:     q <= {q[WIDTH-2:0], q[WIDTH-1]};
            ROR:     q <= {q[0], q[WIDTH-1:1]};
            LOAD:    q <= bus.d;
            default: q <= q;
         endcase
      end
   end

   // Combinational taps follow q at all times, reset included.
   assign bus.q      = q;
   assign bus.qbar   = ~q;
   assign bus.sout_l = q[WIDTH-1];
   assign bus.sout_r = q[0];

   usr_shift_cnt #(
      .WIDTH (WIDTH)
   ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr),
      .inc   (inc),
      .done  (bus.done)
   );

endmodule

// File: tb/tb_usr_sync.sv
// Scoreboard bench for usr_sync (WIDTH=8, default reset/set values).
// The driver pushes the model's expected state per clock; a monitor on the
// falling edge pops and compares it with the register outputs.
module tb_usr_sync;
   import usr_defs::*;

   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   usr_sync_if #(.WIDTH(WIDTH)) bus ();

   usr_sync #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int q;
      int done;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model state: register value, shifts since last wrap, pulse.
   int m_q    = 0;
   int m_cnt  = 0;
   int m_done = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of one clock edge using plain arithmetic on integers.
   task automatic model(input bit r, input bit s, input bit e, input mode_e m,
                        input int dv, input int sl, input int sr);
      bit counts;
      counts = 1'b0;
      m_done = 0;
      if (r) begin
         m_q = 0; m_cnt = 0;
      end else if (s) begin
         m_q = 255; m_cnt = 0;
      end else if (e) begin
         case (m)
            SHL:  begin m_q = (m_q * 2 + sl) % 256;             counts = 1'b1; end
            SHR:  begin m_q = m_q / 2 + sr * 128;               counts = 1'b1; end
            ROL:  begin m_q = (m_q * 2) % 256 + m_q / 128;      counts = 1'b1; end
            ROR:  begin m_q = m_q / 2 + (m_q % 2) * 128;        counts = 1'b1; end
            LOAD: begin m_q = dv; m_cnt = 0; end
            default: ;
         endcase
         if (counts) begin
            m_cnt++;
            if (m_cnt == WIDTH) begin
               m_cnt  = 0;
               m_done = 1;
            end
         end
      end
   endtask

   // Drive one cycle of stimulus, update the model at the edge, queue result.
   task automatic step(input bit r, input bit s, input bit e, input mode_e m,
                       input logic [7:0] dv = 8'h00, input bit sl = 1'b0, input bit sr = 1'b0);
      reset     = r;
      bus.set   = s;
      bus.en    = e;
      bus.mode  = m;
      bus.d     = dv;
      bus.sin_l = sl;
      bus.sin_r = sr;
      @(posedge clk);
      model(r, s, e, m, int'(dv), int'(sl), int'(sr));
      sb.push_back('{q: m_q, done: m_done, cnt: m_cnt});
      #1;
   endtask

   // Monitor: compare every queued expectation against the outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_q",      32'(bus.q),         32'(e.q));
            check("sb_qbar",   32'(bus.qbar),      32'(~e.q & 255));
            check("sb_sout_l", 32'(bus.sout_l),    32'(e.q / 128));
            check("sb_sout_r", 32'(bus.sout_r),    32'(e.q % 2));
            check("sb_done",   32'(bus.done),      32'(e.done));
            check("sb_cnt",    32'(dut.u_cnt.cnt), 32'(e.cnt));
         end
      end
   end

   initial begin
      int drain;

      // Reset and set together: reset wins.
      step(1, 1, 1, LOAD, 8'h5A);
      @(negedge clk);
      check("rst_set_q",    32'(bus.q),    32'h00);
      check("rst_set_qbar", 32'(bus.qbar), 32'hFF);
      check("rst_set_done", 32'(bus.done), 32'h0);

      // Load then shift-left with a 1 entering.
      step(0, 0, 1, LOAD, 8'hA5);
      step(0, 0, 1, SHL, 8'h00, 1'b1);
      @(negedge clk);
      check("shl_q",      32'(bus.q),      32'h4B);
      check("shl_sout_l", 32'(bus.sout_l), 32'h0);

      // Eight shift-rights clear 0x81 and produce one done pulse.
      step(0, 0, 1, LOAD, 8'h81);
      for (int i = 0; i < 8; i++) begin
         step(0, 0, 1, SHR);
         @(negedge clk);
         check("shr_done", 32'(bus.done), (i == 7) ? 32'h1 : 32'h0);
      end
      check("shr_q", 32'(bus.q), 32'h00);
      step(0, 0, 1, HOLD);
      @(negedge clk);
      check("shr_done_after", 32'(bus.done), 32'h0);

      // Rotate-left, then hold with en low.
      step(0, 0, 1, LOAD, 8'h81);
      step(0, 0, 1, ROL);
      @(negedge clk);
      check("rol_q", 32'(bus.q), 32'h03);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, ROL);
         @(negedge clk);
         check("en_low_q",   32'(bus.q),         32'h03);
         check("en_low_cnt", 32'(dut.u_cnt.cnt), 32'h1);
      end

      // Reset mid-count discards the five earlier shifts.
      for (int i = 0; i < 5; i++) step(0, 0, 1, SHL, 8'h00, 1'b1);
      step(1, 0, 1, SHL);
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 1, (i < 8) ? SHL : HOLD);
         @(negedge clk);
         check("rst_mid_done", 32'(bus.done), (i == 7) ? 32'h1 : 32'h0);
      end

      // Reserved modes behave as hold.
      step(0, 0, 1, LOAD, 8'h3C);
      step(0, 0, 1, SHL, 8'h00, 1'b1);
      step(0, 0, 1, SHL);
      step(0, 0, 1, RSV6);
      step(0, 0, 1, RSV7);
      @(negedge clk);
      check("rsv_q",    32'(bus.q),         32'hF2);
      check("rsv_cnt",  32'(dut.u_cnt.cnt), 32'h2);
      check("rsv_done", 32'(bus.done),      32'h0);

      // Preset loads all ones and clears the count.
      step(0, 1, 1, SHL);
      @(negedge clk);
      check("set_q",   32'(bus.q),         32'hFF);
      check("set_cnt", 32'(dut.u_cnt.cnt), 32'h0);

      // Randomised traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 9) < 8), mode_e'(3'($urandom_range(0, 7))),
              8'($urandom), 1'($urandom), 1'($urandom));
      end

      // Drain the scoreboard within a bounded number of cycles.
      drain = 0;
      while (sb.size() > 0 && drain < 10) begin
         @(negedge clk);
         drain++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
      end

      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/usr_sync.md
USR_SYNC -- requirements
Module: usr_sync

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits; legal range WIDTH >= 2.
REQ-002 Parameter RESET_VAL, default all zeros (WIDTH bits), value loaded by reset.
REQ-003 Parameter SET_VAL, default all ones (WIDTH bits), value loaded by set.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 set  input  1  synchronous, active-high preset to SET_VAL.
REQ-007 en  input  1  operation enable; low means hold.
REQ-008 mode  input  3  operation select, encoded per REQ-015.
REQ-009 d  input  WIDTH  parallel load data.
REQ-010 sin_l  input  1  serial input entering bit 0 on shift-left.
REQ-011 sin_r  input  1  serial input entering bit WIDTH-1 on shift-right.
REQ-012 q  output  WIDTH  register contents; qbar  output  WIDTH  bitwise complement of q.
REQ-013 sout_l  output  1  q[WIDTH-1]; sout_r  output  1  q[0] (combinational taps).
REQ-014 done  output  1  registered single-cycle pulse marking completion of WIDTH shift/rotate operations.

Function
REQ-015 mode encoding: 000 hold; 001 shift-left (q <= {q[WIDTH-2:0], sin_l}); 010 shift-right (q <= {sin_r, q[WIDTH-1:1]}); 011 rotate-left; 100 rotate-right; 101 parallel load (q <= d); 110/111 reserved, behave as hold.
REQ-016 Per-edge priority: reset > set > en low (hold) > mode.
REQ-017 qbar, sout_l and sout_r SHALL track q combinationally at all times, including during reset.
REQ-018 An internal shift counter cnt of width $clog2(WIDTH) SHALL count each enabled shift or rotate operation (modes 001-100).
REQ-019 When an enabled shift/rotate occurs with cnt == WIDTH-1, cnt SHALL wrap to 0 and done SHALL be 1 in the following cycle only.
REQ-020 done SHALL be 0 in every other cycle; it never stays high for two consecutive cycles unless wrap conditions occur on consecutive edges (impossible for WIDTH >= 2).
REQ-021 Parallel load (mode 101, en=1) SHALL clear cnt to 0 and SHALL NOT assert done.
REQ-022 Hold, reserved modes and en=0 SHALL leave q and cnt unchanged and drive done to 0 next cycle.
REQ-023 set SHALL load q with SET_VAL, clear cnt and clear done.
REQ-024 Latency: q reflects an operation one clock after the sampling edge; no combinational path from d, mode or serial inputs to q.

Reset
REQ-025 On reset=1 at a rising edge: q = RESET_VAL, qbar = ~RESET_VAL, cnt = 0, done = 0.
REQ-026 Reset asserted mid-count SHALL discard accumulated count; a full WIDTH further shifts are required before the next done.
REQ-027 Reset SHALL take effect regardless of set, en or mode; no asynchronous path exists.

Structure
REQ-028 Mode encodings (HOLD, SHL, SHR, ROL, ROR, LOAD) SHALL be defined as named constants in a shared definitions file, usr_defs, included by the RTL and the bench.
REQ-029 The shift counter and done pulse generator SHALL be a sub-module usr_shift_cnt, parametrised by WIDTH, with inputs clk, reset, clr, inc and outputs done.
REQ-030 Total RTL SHALL be a single sequential process for q plus the counter sub-module; no latches.

Verification (WIDTH=8, defaults)
REQ-031 reset=1 and set=1 same edge -> q=0x00, qbar=0xFF, done=0.
REQ-032 load d=0xA5, then shift-left with sin_l=1 -> q=0x4B, sout_l=0 after the shift.
REQ-033 load 0x81, eight shift-rights with sin_r=0 -> q=0x00; done=1 exactly one cycle after the 8th shift, 0 otherwise.
REQ-034 load 0x81, rotate-left -> q=0x03; then en=0 with mode=ROL for 3 cycles -> q stays 0x03, cnt unchanged.
REQ-035 five shift-lefts, reset, eight shift-lefts -> single done pulse after the 8th post-reset shift only.
REQ-036 mode=110 and 111 with en=1 -> q and cnt unchanged, done=0.
